// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter and the MEM-stage store size codes.
// Imported by the arbiter, its interface and the MEM stage.
package dmem_port_arbiter_pkg;

   localparam int unsigned AddrW = 32;
   localparam int unsigned DataW = 32;

   typedef enum logic {
      StIdle,
      StBusy
   } state_e;

   typedef enum logic {
      OwnIf,
      OwnMem
   } owner_e;

   typedef enum logic [1:0] {
      SzWord = 2'd0,
      SzByte = 2'd1,
      SzHalf = 2'd2,
      Sz3b   = 2'd3
   } size_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and memory-side signals of the shared data-memory port.
// The slave modport is the arbiter's view; master is the pipeline/memory view.
interface dmem_port_arbiter_if;
   import dmem_port_arbiter_pkg::*;

   logic             if_req;
   logic [AddrW-1:0] if_addr;
   logic [DataW-1:0] if_rdata;
   logic             if_valid;
   logic             if_stall;

   logic             mem_rd;
   logic             mem_wr;
   logic [AddrW-1:0] mem_addr;
   logic [DataW-1:0] mem_wdata;
   logic [1:0]       mem_size;
   logic [DataW-1:0] mem_rdata;
   logic             mem_valid;
   logic             mem_stall;

   logic             port_req;
   logic             port_we;
   logic [AddrW-1:0] port_addr;
   logic [DataW-1:0] port_wdata;
   logic [1:0]       port_size;
   logic [DataW-1:0] port_rdata;
   logic             port_ack;

   modport slave (
      input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, mem_size,
             port_rdata, port_ack,
      output if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
             port_req, port_we, port_addr, port_wdata, port_size
   );

   modport master (
      output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, mem_size,
             port_rdata, port_ack,
      input  if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
             port_req, port_we, port_addr, port_wdata, port_size
   );

endinterface

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Saturating count of MEM grants taken while IF was waiting.
// at_limit_o tells the arbiter that IF must win the next decision.
module dmem_starve_counter #(
   parameter int unsigned Limit = 4,
   parameter int unsigned Width = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam logic [Width-1:0] LimitW = Width'(Limit);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < LimitW)) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q >= LimitW);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-ported data memory between instruction fetch and the MEM stage.
// MEM is favoured; a saturating counter forces an IF grant after STARVE_LIMIT MEM wins.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 3
) (
   input logic                clk_i,
   input logic                rst_ni,
   dmem_port_arbiter_if.slave bus
);

   state_e           state_q, state_d;
   owner_e           owner_q, owner_d;
   logic             port_req_q, port_req_d;
   logic             port_we_q, port_we_d;
   logic [AddrW-1:0] port_addr_q, port_addr_d;
   logic [DataW-1:0] port_wdata_q, port_wdata_d;
   logic [1:0]       port_size_q, port_size_d;
   logic [DataW-1:0] if_rdata_q, if_rdata_d;
   logic [DataW-1:0] mem_rdata_q, mem_rdata_d;
   logic             if_valid_q, if_valid_d;
   logic             mem_valid_q, mem_valid_d;

   logic mem_pend;
   logic grant_mem;
   logic grant_if;
   logic at_limit;

   // Grants are only decided in IDLE, so the ack edge never doubles as a grant edge.
   always_comb begin
      mem_pend  = bus.mem_rd | bus.mem_wr;
      grant_mem = (state_q == StIdle) && mem_pend && (!bus.if_req || !at_limit);
      grant_if  = (state_q == StIdle) && !grant_mem && bus.if_req;
   end

   dmem_starve_counter #(
      .Limit (STARVE_LIMIT),
      .Width (CNT_W)
   ) u_starve (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (grant_mem & bus.if_req),
      .clr_i      (grant_if),
      .at_limit_o (at_limit)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      port_req_d   = port_req_q;
      port_we_d    = port_we_q;
      port_addr_d  = port_addr_q;
      port_wdata_d = port_wdata_q;
      port_size_d  = port_size_q;
      if_rdata_d   = if_rdata_q;
      mem_rdata_d  = mem_rdata_q;
      if_valid_d   = 1'b0;
      mem_valid_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (grant_mem) begin
               state_d      = StBusy;
               owner_d      = OwnMem;
               port_req_d   = 1'b1;
               // rd and wr together resolve to a store
               port_we_d    = bus.mem_wr;
               port_addr_d  = bus.mem_addr;
               port_wdata_d = bus.mem_wdata;
               port_size_d  = bus.mem_size;
            end else if (grant_if) begin
               state_d     = StBusy;
               owner_d     = OwnIf;
               port_req_d  = 1'b1;
               port_we_d   = 1'b0;
               port_addr_d = bus.if_addr;
               port_size_d = SzWord;
            end
         end
         StBusy: begin
            if (bus.port_ack) begin
               state_d    = StIdle;
               port_req_d = 1'b0;
               if (owner_q == OwnMem) begin
                  mem_valid_d = 1'b1;
                  if (!port_we_q) begin
                     mem_rdata_d = bus.port_rdata;
                  end
               end else begin
                  if_valid_d = 1'b1;
                  if_rdata_d = bus.port_rdata;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         owner_q      <= OwnIf;
         port_req_q   <= 1'b0;
         port_we_q    <= 1'b0;
         port_addr_q  <= '0;
         port_wdata_q <= '0;
         port_size_q  <= SzWord;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
         if_valid_q   <= 1'b0;
         mem_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         port_req_q   <= port_req_d;
         port_we_q    <= port_we_d;
         port_addr_q  <= port_addr_d;
         port_wdata_q <= port_wdata_d;
         port_size_q  <= port_size_d;
         if_rdata_q   <= if_rdata_d;
         mem_rdata_q  <= mem_rdata_d;
         if_valid_q   <= if_valid_d;
         mem_valid_q  <= mem_valid_d;
      end
   end

   assign bus.port_req   = port_req_q;
   assign bus.port_we    = port_we_q;
   assign bus.port_addr  = port_addr_q;
   assign bus.port_wdata = port_wdata_q;
   assign bus.port_size  = port_size_q;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.mem_rdata  = mem_rdata_q;
   assign bus.if_valid   = if_valid_q;
   assign bus.mem_valid  = mem_valid_q;

   // Stalls follow the live requests so a requester frees up in its valid cycle.
   assign bus.if_stall  = bus.if_req & ~if_valid_q;
   assign bus.mem_stall = (bus.mem_rd | bus.mem_wr) & ~mem_valid_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed table, corner sequences,
// then random traffic against a transaction-level model.
module tb_dmem_port_arbiter;
   import dmem_port_arbiter_pkg::*;

   localparam int Limit = 4;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   n_vec  = 0;
   int   n_err  = 0;

   dmem_port_arbiter_if bus ();

   dmem_port_arbiter #(
      .STARVE_LIMIT (Limit),
      .CNT_W        (3)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        if_req;
      logic        mem_rd;
      logic        mem_wr;
      logic        exp_req;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic        exp_mem;
   } vec_t;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.if_req     = 1'b0;
      bus.if_addr    = '0;
      bus.mem_rd     = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      bus.mem_size   = 2'd0;
      bus.port_rdata = '0;
      bus.port_ack   = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_ni = 1'b0;
      step();
      step();
      #2 rst_ni = 1'b1;
   endtask

   vec_t        vecs[7];
   logic [31:0] exp_mem_order;

   // Transaction-level reference state for the random phase
   logic        m_busy, m_own_mem, m_we, m_if_valid, m_mem_valid;
   logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;
   logic [1:0]  m_size;
   int          starve;
   logic        if_pend, mem_pend;
   int          kind;

   initial begin
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40,  1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1};

      // Reset values, then reset while BUSY
      do_reset();
      check("rst_port_req", bus.port_req, 0);
      check("rst_port_we", bus.port_we, 0);
      check("rst_port_addr", bus.port_addr, 0);
      check("rst_port_wdata", bus.port_wdata, 0);
      check("rst_port_size", bus.port_size, 0);
      check("rst_if_valid", bus.if_valid, 0);
      check("rst_mem_valid", bus.mem_valid, 0);
      check("rst_if_rdata", bus.if_rdata, 0);
      check("rst_mem_rdata", bus.mem_rdata, 0);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h100;
      step();
      check("busy_port_req", bus.port_req, 1);
      check("busy_port_addr", bus.port_addr, 32'h100);
      #1 rst_ni = 1'b0;
      #1;
      check("async_rst_port_req", bus.port_req, 0);
      check("async_rst_port_addr", bus.port_addr, 0);
      bus.if_req = 1'b0;
      step();
      #2 rst_ni = 1'b1;
      bus.port_ack   = 1'b1;
      bus.port_rdata = 32'h5555_AAAA;
      step();
      bus.port_ack = 1'b0;
      check("post_rst_ack_if_valid", bus.if_valid, 0);
      check("post_rst_ack_mem_valid", bus.mem_valid, 0);
      check("post_rst_ack_port_req", bus.port_req, 0);
      check("post_rst_ack_if_rdata", bus.if_rdata, 0);

      // IF only, ack in the third request cycle
      do_reset();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h40;
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("ifonly_req_c%0d", c), bus.port_req, 1);
         check($sformatf("ifonly_stall_c%0d", c), bus.if_stall, 1);
      end
      bus.port_ack   = 1'b1;
      bus.port_rdata = 32'hDEAD_BEEF;
      step();
      bus.port_ack = 1'b0;
      check("ifonly_valid", bus.if_valid, 1);
      check("ifonly_rdata", bus.if_rdata, 32'hDEAD_BEEF);
      check("ifonly_req_drop", bus.port_req, 0);
      check("ifonly_stall_in_valid", bus.if_stall, 0);
      bus.if_req = 1'b0;
      step();
      check("ifonly_valid_pulse", bus.if_valid, 0);
      check("ifonly_stall_after", bus.if_stall, 0);
      check("ifonly_rdata_hold", bus.if_rdata, 32'hDEAD_BEEF);

      // Table of grant decisions from a fresh reset
      do_reset();
      for (int i = 0; i < 7; i++) begin
         bus.if_req    = vecs[i].if_req;
         bus.if_addr   = 32'h40;
         bus.mem_rd    = vecs[i].mem_rd;
         bus.mem_wr    = vecs[i].mem_wr;
         bus.mem_addr  = 32'h200;
         bus.mem_wdata = 32'hCAFE_0000 + i;
         bus.mem_size  = 2'd2;
         step();
         check($sformatf("vec%0d_req", i), bus.port_req, vecs[i].exp_req);
         if (vecs[i].exp_req) begin
            check($sformatf("vec%0d_we", i), bus.port_we, vecs[i].exp_we);
            check($sformatf("vec%0d_addr", i), bus.port_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_size", i), bus.port_size, vecs[i].exp_mem ? 2 : 0);
            bus.port_ack   = 1'b1;
            bus.port_rdata = 32'hA000_0000 + i;
            step();
            bus.port_ack = 1'b0;
            check($sformatf("vec%0d_mem_valid", i), bus.mem_valid, vecs[i].exp_mem);
            check($sformatf("vec%0d_if_valid", i), bus.if_valid, !vecs[i].exp_mem);
            if (vecs[i].exp_mem && !vecs[i].exp_we)
               check($sformatf("vec%0d_mem_rdata", i), bus.mem_rdata, 32'hA000_0000 + i);
            if (!vecs[i].exp_mem)
               check($sformatf("vec%0d_if_rdata", i), bus.if_rdata, 32'hA000_0000 + i);
         end
         clear_inputs();
         step();
      end

      // Load, then a byte store that must leave mem_rdata alone
      do_reset();
      bus.mem_rd   = 1'b1;
      bus.mem_addr = 32'h80;
      step();
      bus.port_ack   = 1'b1;
      bus.port_rdata = 32'h1234_5678;
      step();
      bus.port_ack = 1'b0;
      check("load_valid", bus.mem_valid, 1);
      check("load_rdata", bus.mem_rdata, 32'h1234_5678);
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b1;
      bus.mem_addr  = 32'h1003;
      bus.mem_wdata = 32'h0000_00AB;
      bus.mem_size  = 2'd1;
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("store_we_c%0d", c), bus.port_we, 1);
         check($sformatf("store_size_c%0d", c), bus.port_size, 1);
         check($sformatf("store_wdata_c%0d", c), bus.port_wdata, 32'h0000_00AB);
         check($sformatf("store_addr_c%0d", c), bus.port_addr, 32'h1003);
         check($sformatf("store_stall_c%0d", c), bus.mem_stall, 1);
      end
      bus.port_ack   = 1'b1;
      bus.port_rdata = 32'hFFFF_FFFF;
      step();
      bus.port_ack = 1'b0;
      check("store_valid", bus.mem_valid, 1);
      check("store_rdata_kept", bus.mem_rdata, 32'h1234_5678);
      check("store_req_drop", bus.port_req, 0);
      clear_inputs();
      step();

      // Starvation: both held, minimum-length accesses
      do_reset();
      bus.if_req   = 1'b1;
      bus.if_addr  = 32'h40;
      bus.mem_rd   = 1'b1;
      bus.mem_addr = 32'h300;
      exp_mem_order = 32'b10_1111;
      for (int g = 0; g < 6; g++) begin
         step();
         check($sformatf("starve_req_g%0d", g), bus.port_req, 1);
         check($sformatf("starve_addr_g%0d", g), bus.port_addr,
               exp_mem_order[g] ? 32'h300 : 32'h40);
         bus.port_ack = 1'b1;
         step();
         bus.port_ack = 1'b0;
      end
      clear_inputs();
      step();

      // Stray ack in IDLE is ignored and the next request still wins at once
      do_reset();
      bus.port_ack = 1'b1;
      step();
      bus.port_ack = 1'b0;
      check("stray_if_valid", bus.if_valid, 0);
      check("stray_mem_valid", bus.mem_valid, 0);
      check("stray_port_req", bus.port_req, 0);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h44;
      step();
      check("stray_then_grant", bus.port_req, 1);
      check("stray_then_addr", bus.port_addr, 32'h44);
      bus.port_ack = 1'b1;
      step();
      clear_inputs();
      step();

      // Random traffic against the reference model
      do_reset();
      m_busy = 0; m_own_mem = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_size = 0;
      m_if_valid = 0; m_mem_valid = 0; m_if_rdata = 0; m_mem_rdata = 0;
      starve = 0; if_pend = 0; mem_pend = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (m_if_valid) if_pend = 0;
         if (m_mem_valid) mem_pend = 0;
         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend     = 1;
            bus.if_addr = 32'($urandom) & 32'hFFFF_FFFC;
         end
         bus.if_req = if_pend;
         if (!mem_pend && $urandom_range(0, 2) == 0) begin
            mem_pend      = 1;
            kind          = $urandom_range(0, 3);
            bus.mem_rd    = (kind != 1);
            bus.mem_wr    = (kind == 1) || (kind == 2);
            bus.mem_addr  = 32'($urandom);
            bus.mem_wdata = 32'($urandom);
            bus.mem_size  = 2'($urandom_range(0, 3));
         end
         if (!mem_pend) begin
            bus.mem_rd = 1'b0;
            bus.mem_wr = 1'b0;
         end
         bus.port_ack   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         bus.port_rdata = 32'($urandom);
         step();

         m_if_valid  = 0;
         m_mem_valid = 0;
         if (m_busy) begin
            if (bus.port_ack) begin
               m_busy = 0;
               if (m_own_mem) begin
                  m_mem_valid = 1;
                  if (!m_we) m_mem_rdata = bus.port_rdata;
               end else begin
                  m_if_valid = 1;
                  m_if_rdata = bus.port_rdata;
               end
            end
         end else if ((bus.mem_rd || bus.mem_wr) && (!bus.if_req || starve < Limit)) begin
            m_busy = 1; m_own_mem = 1; m_we = bus.mem_wr;
            m_addr = bus.mem_addr; m_wdata = bus.mem_wdata; m_size = bus.mem_size;
            if (bus.if_req) starve++;
         end else if (bus.if_req) begin
            m_busy = 1; m_own_mem = 0; m_we = 0; m_addr = bus.if_addr; m_size = 0;
            starve = 0;
         end

         check("rnd_port_req", bus.port_req, m_busy);
         if (m_busy) begin
            check("rnd_port_we", bus.port_we, m_we);
            check("rnd_port_addr", bus.port_addr, m_addr);
            check("rnd_port_size", bus.port_size, m_size);
            if (m_own_mem) check("rnd_port_wdata", bus.port_wdata, m_wdata);
         end
         check("rnd_if_valid", bus.if_valid, m_if_valid);
         check("rnd_mem_valid", bus.mem_valid, m_mem_valid);
         check("rnd_if_rdata", bus.if_rdata, m_if_rdata);
         check("rnd_mem_rdata", bus.mem_rdata, m_mem_rdata);
         check("rnd_if_stall", bus.if_stall, bus.if_req & !m_if_valid);
         check("rnd_mem_stall", bus.mem_stall, (bus.mem_rd | bus.mem_wr) & !m_mem_valid);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Arbitrates one shared single-ported memory between the instruction-fetch requester (IF) and the MEM-stage load/store requester (MEM). Sequences each access through a req/ack handshake to a variable-latency memory and returns read data to the winner. Drives per-requester stall so the pipeline freezes until its access completes. Favours MEM (older instruction) and bounds IF starvation with a counter.

Parameters:
STARVE_LIMIT, 4, consecutive MEM grants while IF waits before IF is forced to win
CNT_W, 3, width of starvation counter; must hold STARVE_LIMIT

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  asynchronous, active-low reset
if_req  in  1  IF requests a word read; held until if_valid
if_addr  in  32  IF read address, word aligned
if_rdata  out  32  IF read data, valid when if_valid
if_valid  out  1  one-cycle pulse, IF access complete
if_stall  out  1  IF must hold
mem_rd  in  1  MEM load request; held until mem_valid
mem_wr  in  1  MEM store request; held until mem_valid
mem_addr  in  32  MEM address (already aligned/adjusted by MEM stage)
mem_wdata  in  32  store data
mem_size  in  2  store size code: 0 word, 1 byte, 2 half, 3 three bytes
mem_rdata  out  32  load data, valid when mem_valid
mem_valid  out  1  one-cycle pulse, MEM access complete
mem_stall  out  1  MEM stage must hold
port_req  out  1  memory request, held until port_ack
port_we  out  1  1 = write
port_addr  out  32  memory address
port_wdata  out  32  memory write data
port_size  out  2  memory write size code
port_rdata  in  32  memory read data, sampled with port_ack
port_ack  in  1  memory completion, single-cycle

Behaviour:
- Reset (async, RESET=0): state IDLE; port_req, port_we, if_valid, mem_valid = 0; port_addr, port_wdata, if_rdata, mem_rdata = 0; port_size = 0; starve_cnt = 0; owner = IF.
- States: IDLE, BUSY. All port_* outputs registered.
- IDLE grant decision on a rising edge: mem_pend = mem_rd|mem_wr.
  - mem_pend and (!if_req or starve_cnt < STARVE_LIMIT): grant MEM; port_we = mem_wr; latch mem_addr/mem_wdata/mem_size.
  - else if if_req: grant IF; port_we = 0; port_addr = if_addr; port_size = 0.
  - else stay IDLE.
  - Grant -> BUSY, port_req = 1 from the next cycle.
- mem_rd and mem_wr both high: treated as a write (port_we = 1).
- BUSY: port_* held stable. On port_ack: port_req = 0, next state IDLE; owner's valid pulses 1 for exactly one cycle; load or IF read copies port_rdata into owner's rdata register; write leaves mem_rdata unchanged.
- Minimum access: grant edge, >=1 BUSY cycle, ack edge; new grant on the edge after returning to IDLE (no back-to-back grant on the ack edge).
- starve_cnt: +1 on each MEM grant while if_req = 1, saturating at STARVE_LIMIT; cleared on every IF grant; unchanged otherwise.
- Stalls (combinational): if_stall = if_req & !if_valid; mem_stall = (mem_rd|mem_wr) & !mem_valid.
- port_ack while IDLE ignored; no state change, no valid pulse.
- Requester dropping its request while BUSY: access still completes; valid still pulses; data is discarded by the requester.
- Reset asserted while BUSY: port_req drops immediately; any later ack ignored.
- rdata registers hold their value until the next completion for the same owner.

Decomposition:
- Shared package: state encoding (IDLE, BUSY), owner encoding (OWN_IF, OWN_MEM), size codes (SZ_WORD=0, SZ_BYTE=1, SZ_HALF=2, SZ_3B=3) shared with the MEM stage.
- One natural sub-module: dmem_starve_counter (saturating counter with inc/clr and at_limit output).

Test Plan:
- Reset mid-BUSY: grant IF at 0x100, pull RESET low before ack -> port_req=0 at once; ack after release ignored; all outputs 0.
- IF only: if_req, if_addr=0x0000_0040, memory acks after 3 cycles with 0xDEADBEEF -> port_req high 3 cycles, if_valid one cycle, if_rdata=0xDEADBEEF, if_stall low the cycle after valid.
- Simultaneous requests: if_req and mem_rd at 0x200, both held -> MEM granted first (port_we=0, port_addr=0x200); IF granted after mem_valid; mem_stall and if_stall each high until their own valid.
- Store: mem_wr, addr 0x1003, wdata 0x000000AB, size 1 -> port_we=1, port_size=1, port_wdata=0x000000AB, stable until ack; mem_rdata unchanged.
- Starvation: MEM requests continuously, if_req held, STARVE_LIMIT=4 -> exactly 4 MEM grants, then IF grant, then counter 0 and MEM wins again.
- Stray ack in IDLE: port_ack pulse with no request -> no valid pulse, state stays IDLE.
